// File: rtl/alu_issue_stage.sv
// ID/EX issue stage in front of the 32-bit ALU.
// Decodes MIPS opcode/funct into the ALU control code, selects and extends
// operands A/B, and registers them into the EX slot with stall/flush handling.
//
// Handshake: InValid marks a decoded instruction on the ID side and is
// sampled only on a rising edge where neither Stall nor Flush is high. There
// is no ready back to ID. While Stall is high, ID must hold its instruction,
// because this stage does not capture it. ExValid marks a live instruction in
// the EX slot for exactly as many cycles as the slot holds it.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              InValid,
    input  logic [5:0]        Opcode,
    input  logic [5:0]        Funct,
    input  logic [4:0]        Shamt,
    input  logic [15:0]       Imm16,
    input  logic [DATA_W-1:0] RsData,
    input  logic [DATA_W-1:0] RtData,
    input  logic              Stall,
    input  logic              Flush,
    output logic              ExValid,
    output logic [CTRL_W-1:0] ALUControl,
    output logic [DATA_W-1:0] OpA,
    output logic [DATA_W-1:0] OpB,
    output logic              Illegal,
    output logic [CNT_W-1:0]  IssueCount
);

    // ALU control codes understood by the downstream ALU
    localparam logic [CTRL_W-1:0] ALU_ADD = CTRL_W'(5'b00000);
    localparam logic [CTRL_W-1:0] ALU_SUB = CTRL_W'(5'b00001);
    localparam logic [CTRL_W-1:0] ALU_MUL = CTRL_W'(5'b00010);
    localparam logic [CTRL_W-1:0] ALU_OR  = CTRL_W'(5'b00011);
    localparam logic [CTRL_W-1:0] ALU_NOR = CTRL_W'(5'b00100);
    localparam logic [CTRL_W-1:0] ALU_SLT = CTRL_W'(5'b00101);
    localparam logic [CTRL_W-1:0] ALU_SLL = CTRL_W'(5'b00110);
    localparam logic [CTRL_W-1:0] ALU_SRL = CTRL_W'(5'b00111);
    localparam logic [CTRL_W-1:0] ALU_AND = CTRL_W'(5'b01000);
    localparam logic [CTRL_W-1:0] ALU_XOR = CTRL_W'(5'b01001);

    // Operand candidates
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] shamt_ext;
    logic [DATA_W-1:0] rs_shamt;

    assign imm_sext  = {{(DATA_W-16){Imm16[15]}}, Imm16};
    assign imm_zext  = {{(DATA_W-16){1'b0}}, Imm16};
    assign shamt_ext = {{(DATA_W-5){1'b0}}, Shamt};
    assign rs_shamt  = {{(DATA_W-5){1'b0}}, RsData[4:0]};

    // Decode result for the instruction currently presented by ID
    logic              dec_legal;
    logic [CTRL_W-1:0] dec_ctrl;
    logic [DATA_W-1:0] dec_a;
    logic [DATA_W-1:0] dec_b;

    // Decode opcode/funct into control code and operand selection
    always_comb begin
        dec_legal = 1'b0;
        dec_ctrl  = '0;
        dec_a     = '0;
        dec_b     = '0;
        case (Opcode)
            6'b000000: begin
                dec_legal = 1'b1;
                dec_a     = RsData;
                dec_b     = RtData;
                case (Funct)
                    6'b100000, 6'b100001: dec_ctrl = ALU_ADD;
                    6'b100010, 6'b100011: dec_ctrl = ALU_SUB;
                    6'b100100:            dec_ctrl = ALU_AND;
                    6'b100101:            dec_ctrl = ALU_OR;
                    6'b100110:            dec_ctrl = ALU_XOR;
                    6'b100111:            dec_ctrl = ALU_NOR;
                    6'b101010:            dec_ctrl = ALU_SLT;
                    6'b000000: begin dec_ctrl = ALU_SLL; dec_a = shamt_ext; end
                    6'b000010: begin dec_ctrl = ALU_SRL; dec_a = shamt_ext; end
                    6'b000100: begin dec_ctrl = ALU_SLL; dec_a = rs_shamt;  end
                    6'b000110: begin dec_ctrl = ALU_SRL; dec_a = rs_shamt;  end
                    default: begin
                        dec_legal = 1'b0;
                        dec_a     = '0;
                        dec_b     = '0;
                    end
                endcase
            end
            6'b011100: begin
                if (Funct == 6'b000010) begin
                    dec_legal = 1'b1;
                    dec_ctrl  = ALU_MUL;
                    dec_a     = RsData;
                    dec_b     = RtData;
                end
            end
            6'b001000, 6'b001001, 6'b100011, 6'b101011: begin
                dec_legal = 1'b1;
                dec_ctrl  = ALU_ADD;
                dec_a     = RsData;
                dec_b     = imm_sext;
            end
            6'b001010: begin
                dec_legal = 1'b1;
                dec_ctrl  = ALU_SLT;
                dec_a     = RsData;
                dec_b     = imm_sext;
            end
            6'b001100, 6'b001101, 6'b001110: begin
                dec_legal = 1'b1;
                dec_a     = RsData;
                dec_b     = imm_zext;
                case (Opcode[1:0])
                    2'b00:   dec_ctrl = ALU_AND;
                    2'b01:   dec_ctrl = ALU_OR;
                    default: dec_ctrl = ALU_XOR;
                endcase
            end
            6'b000100, 6'b000101: begin
                dec_legal = 1'b1;
                dec_ctrl  = ALU_SUB;
                dec_a     = RsData;
                dec_b     = RtData;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // EX slot registers: flush beats stall, stall beats capture
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ExValid    <= 1'b0;
            ALUControl <= '0;
            OpA        <= '0;
            OpB        <= '0;
            Illegal    <= 1'b0;
            IssueCount <= '0;
        end else if (Flush) begin
            ExValid    <= 1'b0;
            ALUControl <= '0;
            OpA        <= '0;
            OpB        <= '0;
            Illegal    <= 1'b0;
        end else if (Stall) begin
            Illegal    <= 1'b0;
        end else if (InValid && dec_legal) begin
            ExValid    <= 1'b1;
            ALUControl <= dec_ctrl;
            OpA        <= dec_a;
            OpB        <= dec_b;
            Illegal    <= 1'b0;
            IssueCount <= IssueCount + 1'b1;
        end else begin
            // Bubble; an unknown instruction is dropped and flagged for one cycle
            ExValid    <= 1'b0;
            ALUControl <= '0;
            OpA        <= '0;
            OpB        <= '0;
            Illegal    <= InValid;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed cases plus randomized
// traffic compared every cycle against a behavioural model.
module tb_alu_issue_stage;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    logic Rst_n;
    always #5 Clk = ~Clk;

    logic        InValid, Stall, Flush;
    logic [5:0]  Opcode, Funct;
    logic [4:0]  Shamt;
    logic [15:0] Imm16;
    logic [31:0] RsData, RtData;

    logic        ExValid, Illegal;
    logic [4:0]  ALUControl;
    logic [31:0] OpA, OpB, IssueCount;

    // narrow-counter copy used to exercise wrap-around
    logic        w_valid, w_ill;
    logic [4:0]  w_ctrl;
    logic [31:0] w_a, w_b;
    logic [3:0]  w_cnt;

    alu_issue_stage dut (
        .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .Opcode(Opcode),
        .Funct(Funct), .Shamt(Shamt), .Imm16(Imm16), .RsData(RsData),
        .RtData(RtData), .Stall(Stall), .Flush(Flush), .ExValid(ExValid),
        .ALUControl(ALUControl), .OpA(OpA), .OpB(OpB), .Illegal(Illegal),
        .IssueCount(IssueCount)
    );

    alu_issue_stage #(.CNT_W(4)) dut_w (
        .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .Opcode(Opcode),
        .Funct(Funct), .Shamt(Shamt), .Imm16(Imm16), .RsData(RsData),
        .RtData(RtData), .Stall(Stall), .Flush(Flush), .ExValid(w_valid),
        .ALUControl(w_ctrl), .OpA(w_a), .OpB(w_b), .Illegal(w_ill),
        .IssueCount(w_cnt)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        legal;
        logic [4:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
    } dec_t;

    // Map each instruction to its ALU operation and operand form:
    // form 0 = rs,rt  1 = rs,sext(imm)  2 = rs,zext(imm)  3 = shamt,rt  4 = rs mod 32,rt
    function automatic dec_t ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                        input logic [4:0] sh, input logic [15:0] imm,
                                        input logic [31:0] rs, input logic [31:0] rt);
        dec_t d;
        int form;
        int alu;
        logic signed [31:0] sx;
        alu = -1;
        form = 0;
        if (op == 0) begin
            case (int'(fn))
                32, 33: alu = 0;
                34, 35: alu = 1;
                36: alu = 8;
                37: alu = 3;
                38: alu = 9;
                39: alu = 4;
                42: alu = 5;
                0:  begin alu = 6; form = 3; end
                2:  begin alu = 7; form = 3; end
                4:  begin alu = 6; form = 4; end
                6:  begin alu = 7; form = 4; end
                default: alu = -1;
            endcase
        end else if (op == 28) begin
            if (fn == 2) alu = 2;
        end else begin
            case (int'(op))
                8, 9, 35, 43: begin alu = 0; form = 1; end
                10: begin alu = 5; form = 1; end
                12: begin alu = 8; form = 2; end
                13: begin alu = 3; form = 2; end
                14: begin alu = 9; form = 2; end
                4, 5: alu = 1;
                default: alu = -1;
            endcase
        end
        d = '0;
        if (alu >= 0) begin
            d.legal = 1'b1;
            d.ctrl  = 5'(alu);
            sx = $signed(imm);
            case (form)
                1: begin d.a = rs; d.b = sx; end
                2: begin d.a = rs; d.b = 32'(imm); end
                3: begin d.a = 32'(sh); d.b = rt; end
                4: begin d.a = rs % 32; d.b = rt; end
                default: begin d.a = rs; d.b = rt; end
            endcase
        end
        return d;
    endfunction

    logic        m_valid = 0, m_ill = 0;
    logic [4:0]  m_ctrl = 0;
    logic [31:0] m_a = 0, m_b = 0, m_cnt = 0;
    logic [3:0]  m_cnt4 = 0;

    localparam int W = 1 + 1 + 5 + 32 + 32 + 32 + 4;
    logic [W-1:0] exp_q[$];

    // Model advances on each clock edge; predictions are queued for the compare process
    always @(posedge Clk or negedge Rst_n) begin
        dec_t d;
        if (!Rst_n) begin
            m_valid = 0; m_ill = 0; m_ctrl = 0; m_a = 0; m_b = 0;
            m_cnt = 0; m_cnt4 = 0;
            exp_q.delete();
        end else begin
            d = ref_decode(Opcode, Funct, Shamt, Imm16, RsData, RtData);
            if (Flush) begin
                m_valid = 0; m_ctrl = 0; m_a = 0; m_b = 0; m_ill = 0;
            end else if (Stall) begin
                m_ill = 0;
            end else if (InValid && d.legal) begin
                m_valid = 1; m_ctrl = d.ctrl; m_a = d.a; m_b = d.b; m_ill = 0;
                m_cnt = m_cnt + 1;
                m_cnt4 = m_cnt4 + 1;
            end else begin
                m_valid = 0; m_ctrl = 0; m_a = 0; m_b = 0; m_ill = InValid;
            end
            exp_q.push_back({m_valid, m_ill, m_ctrl, m_a, m_b, m_cnt, m_cnt4});
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge Clk) begin
        logic [W-1:0] e;
        if (Rst_n === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ExValid",    32'(ExValid),    32'(e[106]));
            chk("Illegal",    32'(Illegal),    32'(e[105]));
            chk("ALUControl", 32'(ALUControl), 32'(e[104:100]));
            chk("OpA",        OpA,             e[99:68]);
            chk("OpB",        OpB,             e[67:36]);
            chk("IssueCount", IssueCount,      e[35:4]);
            chk("IssueCount4", 32'(w_cnt),     32'(e[3:0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [15:0] imm,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic st, input logic fl);
        InValid = v; Opcode = op; Funct = fn; Shamt = sh; Imm16 = imm;
        RsData = rs; RtData = rt; Stall = st; Flush = fl;
    endtask

    // Present inputs, let one edge capture them, return after the next falling edge
    task automatic step(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] sh, input logic [15:0] imm,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic st, input logic fl);
        drive(v, op, fn, sh, imm, rs, rt, st, fl);
        @(posedge Clk);
        @(negedge Clk);
        #2;
    endtask

    logic [5:0] op_tab [18] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0,
                                6'd0, 6'd28, 6'd8, 6'd10, 6'd12, 6'd13, 6'd14, 6'd4, 6'd43};
    logic [5:0] fn_tab [18] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd0, 6'd2,
                                6'd6, 6'd2, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};

    // ---------------- stimulus ----------------
    initial begin
        Rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst ExValid", 32'(ExValid), 0);
        chk("rst IssueCount", IssueCount, 0);
        chk("rst Illegal", 32'(Illegal), 0);
        repeat (2) @(negedge Clk);
        #2 Rst_n = 1'b1;

        // add rs=5 rt=7
        step(1, 6'b000000, 6'b100000, 0, 0, 5, 7, 0, 0);
        chk("add ExValid", 32'(ExValid), 1);
        chk("add ctrl", 32'(ALUControl), 0);
        chk("add OpA", OpA, 5);
        chk("add OpB", OpB, 7);
        chk("add count", IssueCount, 1);

        // immediate extension
        step(1, 6'b001000, 0, 0, 16'hFFFF, 3, 0, 0, 0);
        chk("addi OpB", OpB, 32'hFFFFFFFF);
        step(1, 6'b001100, 0, 0, 16'hFFFF, 3, 0, 0, 0);
        chk("andi OpB", OpB, 32'h0000FFFF);
        chk("andi ctrl", 32'(ALUControl), 32'h8);
        step(1, 6'b000000, 6'b000000, 4, 0, 32'hDEAD, 1, 0, 0);
        chk("sll OpA", OpA, 4);
        chk("sll OpB", OpB, 1);
        chk("sll ctrl", 32'(ALUControl), 6);

        // sub, then stall with a new instruction presented
        step(1, 6'b000000, 6'b100010, 0, 0, 9, 3, 0, 0);
        chk("sub count", IssueCount, 5);
        for (int i = 0; i < 3; i++) begin
            step(1, 6'b000000, 6'b100000, 0, 0, 100, 200, 1, 0);
            chk("stall ExValid", 32'(ExValid), 1);
            chk("stall ctrl", 32'(ALUControl), 1);
            chk("stall OpA", OpA, 9);
            chk("stall OpB", OpB, 3);
            chk("stall count", IssueCount, 5);
        end
        step(1, 6'b000000, 6'b100000, 0, 0, 100, 200, 1, 1);
        chk("flush ExValid", 32'(ExValid), 0);
        chk("flush OpA", OpA, 0);
        chk("flush OpB", OpB, 0);
        chk("flush ctrl", 32'(ALUControl), 0);
        chk("flush count", IssueCount, 5);

        // illegal opcode pulses Illegal for one cycle
        step(1, 6'b111111, 0, 0, 0, 1, 2, 0, 0);
        chk("ill Illegal", 32'(Illegal), 1);
        chk("ill ExValid", 32'(ExValid), 0);
        chk("ill count", IssueCount, 5);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("ill pulse end", 32'(Illegal), 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int k;
            logic v, st, fl;
            logic [5:0] op, fn;
            k  = $urandom_range(0, 17);
            op = op_tab[k];
            fn = fn_tab[k];
            if ($urandom_range(0, 7) == 0) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end
            v  = ($urandom_range(0, 5) != 0);
            st = ($urandom_range(0, 7) == 0);
            fl = ($urandom_range(0, 15) == 0);
            step(v, op, fn, 5'($urandom), 16'($urandom), $urandom, $urandom, st, fl);
        end

        // asynchronous reset between edges while the slot is live
        step(1, 6'b000000, 6'b100000, 0, 0, 11, 22, 0, 0);
        chk("pre-rst ExValid", 32'(ExValid), 1);
        #1 Rst_n = 1'b0;
        #1;
        chk("mid-rst ExValid", 32'(ExValid), 0);
        chk("mid-rst OpA", OpA, 0);
        chk("mid-rst OpB", OpB, 0);
        chk("mid-rst ctrl", 32'(ALUControl), 0);
        chk("mid-rst Illegal", 32'(Illegal), 0);
        chk("mid-rst count", IssueCount, 0);
        drive(1, 6'b000000, 6'b100000, 0, 0, 1, 1, 0, 0);
        repeat (2) @(negedge Clk);
        #2;
        chk("rst hold count", IssueCount, 0);
        Rst_n = 1'b1;

        // 16 issues wrap the 4-bit counter to zero
        for (int i = 0; i < 16; i++)
            step(1, 6'b001001, 0, 0, 16'(i), 32'(i), 0, 0, 0);
        chk("wrap cnt4", 32'(w_cnt), 0);
        chk("wrap cnt32", IssueCount, 16);
        step(1, 6'b001001, 0, 0, 1, 1, 0, 0, 0);
        chk("post-wrap cnt4", 32'(w_cnt), 1);

        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX issue stage that drives the 32-bit ALU: decodes MIPS opcode/funct into the 5-bit ALUControl code and selects/extends operands A and B.
- Registers the results into the EX pipeline slot with valid, stall and flush handling.
- Sits between the register-file read (ID) and the combinational ALU (EX). Its outputs connect directly to the ALU's ALUControl, A and B inputs.

Parameters:
DATA_W, 32, operand width
CTRL_W, 5, ALUControl width
CNT_W, 32, width of issued-instruction counter

Ports:
Clk  input  1  rising-edge clock
Rst_n  input  1  asynchronous active-low reset
InValid  input  1  ID holds a decoded instruction
Opcode  input  6  instr[31:26]
Funct  input  6  instr[5:0]
Shamt  input  5  instr[10:6]
Imm16  input  16  instr[15:0]
RsData  input  DATA_W  register rs value
RtData  input  DATA_W  register rt value
Stall  input  1  hold EX slot, do not capture
Flush  input  1  kill EX slot
ExValid  output  1  EX slot holds a live instruction
ALUControl  output  CTRL_W  to ALU
OpA  output  DATA_W  ALU input A
OpB  output  DATA_W  ALU input B
Illegal  output  1  one-cycle pulse, unknown instruction dropped
IssueCount  output  CNT_W  count of instructions issued into EX

Behaviour:
- ALUControl codes: add 00000, sub 00001, mul 00010, or 00011, nor 00100, slt 00101 (signed), sll 00110 (B<<A), srl 00111 (B>>A), and 01000, xor 01001.
- Opcode 000000 (R-type), by Funct:
  - add/addu 100000/100001 -> add; sub/subu 100010/100011 -> sub; A=Rs, B=Rt.
  - and 100100, or 100101, xor 100110, nor 100111, slt 101010: A=Rs, B=Rt.
  - sll 000000 / srl 000010: A={27'b0,Shamt}, B=Rt.
  - sllv 000100 / srlv 000110: A={27'b0,Rs[4:0]}, B=Rt.
- Opcode 011100 with Funct 000010 -> mul, A=Rs, B=Rt.
- I-type:
  - addi 001000, addiu 001001, lw 100011, sw 101011 -> add, A=Rs, B=sign-extended Imm16.
  - slti 001010 -> slt, B=sign-extended Imm16.
  - andi 001100, ori 001101, xori 001110 -> and/or/xor, B=zero-extended Imm16.
  - beq 000100, bne 000101 -> sub, A=Rs, B=Rt.
- Any other opcode/funct with InValid=1 is illegal.
- Latency: 1 cycle, from capture edge to outputs.
- Priority at each rising edge:
  - Flush: ExValid<=0; OpA, OpB, ALUControl<=0; Illegal<=0; counter unchanged. Flush overrides Stall.
  - else Stall: all registers hold, Illegal<=0.
  - else InValid=1 and legal: ExValid<=1, fields latched, IssueCount+=1.
  - else InValid=1 and illegal: ExValid<=0, fields<=0, Illegal<=1 for exactly one cycle.
  - else: ExValid<=0, fields<=0.
- IssueCount wraps from all-ones to 0 silently.
- Reset (Rst_n low, async, any time including mid-stall): ExValid, ALUControl, OpA, OpB, Illegal, IssueCount all 0 immediately. First capture occurs on the first rising edge after Rst_n rises.
- Outputs are purely registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset mid-operation: with ExValid=1, drop Rst_n asynchronously between edges -> all outputs 0 before next edge; IssueCount=0.
- add: Opcode 000000, Funct 100000, Rs=5, Rt=7, InValid=1 -> next cycle ExValid=1, ALUControl=00000, OpA=5, OpB=7, IssueCount=1.
- Immediate extension: addi Imm16=16'hFFFF -> OpB=32'hFFFFFFFF; andi Imm16=16'hFFFF -> OpB=32'h0000FFFF, ALUControl=01000. sll Shamt=4, Rt=1 -> OpA=4, OpB=1, ALUControl=00110.
- Stall/flush: issue sub, then hold Stall=1 for 3 cycles with a new instruction presented -> outputs unchanged, count unchanged. Then Stall=1 and Flush=1 together -> ExValid=0, fields 0.
- Illegal: Opcode 111111, InValid=1 -> Illegal high exactly 1 cycle, ExValid=0, IssueCount unchanged.
- Wrap: preload by issuing until IssueCount=32'hFFFFFFFF (or force CNT_W=4 and issue 16) -> next issue gives 0.
